regfile_scrub: RTL and testbench

REGFILE_SCRUB -- requirements
Module: regfile_scrub

---
 rtl/regfile_scrub.sv | 162 ++++++++++++++++
 tb/tb_regfile_scrub.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scrub.sv
// rtl/regfile_scrub.sv - register file with two read ports, one write port and a clear-all scrubber
//
// Purpose: DEPTH x DATA_W register file. One write port, two independent
// registered read ports with write-first bypass, and a scrub FSM that walks
// every entry writing zero after a clr request. While scrubbing, writes and
// reads are discarded; discarded writes pulse write_drop.
//
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
//
// Ports:
//   clk                    clock, rising edge
//   rst                    asynchronous active-low reset
//   write_en/add/data      write request
//   read_en1/2, read_add1/2 read requests
//   clr                    start a scrub of all entries
//   read_data1/2           registered read data (held when no read)
//   read_valid1/2          one-cycle read valid pulse
//   busy                   scrub in progress
//   write_drop             one-cycle pulse after a discarded write
module regfile_scrub #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en1,
  input  logic              read_en2,
  input  logic [ADDR_W-1:0] read_add1,
  input  logic [ADDR_W-1:0] read_add2,
  input  logic              clr,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_valid1,
  output logic              read_valid2,
  output logic              busy,
  output logic              write_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, SCRUB} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic              rvalid1_q, rvalid1_d, rvalid2_q, rvalid2_d;
  logic              drop_q, drop_d;

  logic              busy_w;
  logic              wr_ok;
  logic              byp1, byp2;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign busy_w = (state_q == SCRUB);
  // A user write commits only when idle and not colliding with a clr request.
  assign wr_ok  = write_en & ~busy_w & ~clr;

`ifdef REGFILE_ZERO_REG_EN
  // Entry 0 is constant zero, so forwarding a write to it would be wrong.
  assign byp1 = wr_ok && (write_add == read_add1) && (read_add1 != '0);
  assign byp2 = wr_ok && (write_add == read_add2) && (read_add2 != '0);
`else
  assign byp1 = wr_ok && (write_add == read_add1);
  assign byp2 = wr_ok && (write_add == read_add2);
`endif

  // Scrub FSM: clr in IDLE starts a walk from entry 0; the last entry ends it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = SCRUB;
          cnt_d   = '0;
        end
      end
      SCRUB: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single physical write port shared by the scrubber and user writes.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = write_add;
    mem_wd = write_data;
    if (busy_w) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
`ifdef REGFILE_ZERO_REG_EN
    if (mem_wa == '0) begin
      mem_we = 1'b0;
    end
`endif
  end

  always_comb begin
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    rvalid1_d = 1'b0;
    rvalid2_d = 1'b0;
    if (read_en1 && !busy_w) begin
      rvalid1_d = 1'b1;
      rdata1_d  = byp1 ? write_data : mem_q[read_add1];
    end
    if (read_en2 && !busy_w) begin
      rvalid2_d = 1'b1;
      rdata2_d  = byp2 ? write_data : mem_q[read_add2];
    end
    drop_d = write_en & (busy_w | clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      rvalid1_q <= 1'b0;
      rvalid2_q <= 1'b0;
      drop_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      rvalid1_q <= rvalid1_d;
      rvalid2_q <= rvalid2_d;
      drop_q    <= drop_d;
      if (mem_we) begin
        mem_q[mem_wa] <= mem_wd;
      end
    end
  end

  assign read_data1  = rdata1_q;
  assign read_data2  = rdata2_q;
  assign read_valid1 = rvalid1_q;
  assign read_valid2 = rvalid2_q;
  assign busy        = busy_w;
  assign write_drop  = drop_q;

endmodule

// File: tb/tb_regfile_scrub.sv
// tb/tb_regfile_scrub.sv - scoreboard bench for regfile_scrub with a behavioural reference model
module tb_regfile_scrub;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  typedef struct {
    int            stamp;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          write_en;
  logic [AW-1:0] write_add;
  logic [DW-1:0] write_data;
  logic          read_en1, read_en2;
  logic [AW-1:0] read_add1, read_add2;
  logic          clr;
  logic [DW-1:0] read_data1, read_data2;
  logic          read_valid1, read_valid2;
  logic          busy;
  logic          write_drop;

  regfile_scrub #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_add(write_add), .write_data(write_data),
    .read_en1(read_en1), .read_en2(read_en2),
    .read_add1(read_add1), .read_add2(read_add2),
    .clr(clr),
    .read_data1(read_data1), .read_data2(read_data2),
    .read_valid1(read_valid1), .read_valid2(read_valid2),
    .busy(busy), .write_drop(write_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [DW-1:0] mdl [DEPTH];
  int            scrub_left = 0;
  exp_t          q1[$];
  exp_t          q2[$];
  int            qdrop[$];
  bit            qbusy[$];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last2 = '0;

  int  checks = 0;
  int  passes = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bad(input string name);
    checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit acc,
                                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (ZR && a == '0) return '0;
    if (acc && wa == a) return wd;
    return mdl[a];
  endfunction

  // Issue one clock's worth of stimulus; expectations are queued before the edge.
  task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit r1, input logic [AW-1:0] a1,
                      input bit r2, input logic [AW-1:0] a2, input bit c);
    bit busy_now, acc;
    busy_now = (scrub_left > 0);
    acc      = we && !busy_now && !c;
    if (r1 && !busy_now) q1.push_back('{cyc + 1, model_read(a1, acc, wa, wd)});
    if (r2 && !busy_now) q2.push_back('{cyc + 1, model_read(a2, acc, wa, wd)});
    if (we && (busy_now || c)) qdrop.push_back(cyc + 1);
    if (busy_now) begin
      mdl[DEPTH - scrub_left] = '0;
      scrub_left--;
    end else if (c) begin
      scrub_left = DEPTH;
    end
    if (acc && !(ZR && wa == '0)) mdl[wa] = wd;
    qbusy.push_back(scrub_left > 0);
    write_en = we; write_add = wa; write_data = wd;
    read_en1 = r1; read_add1 = a1; read_en2 = r2; read_add2 = a2; clr = c;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic settle();
    for (int k = 0; k < DEPTH + 2 && scrub_left > 0; k++) idle();
  endtask

  // Asynchronous reset applied mid-cycle, away from any clock edge.
  task automatic mid_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid1", read_valid1, 0);
    chk("rst_valid2", read_valid2, 0);
    chk("rst_data1", read_data1, 0);
    chk("rst_data2", read_data2, 0);
    chk("rst_drop", write_drop, 0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    scrub_left = 0;
    q1.delete(); q2.delete(); qdrop.delete();
    last1 = '0; last2 = '0;
    write_en = 0; read_en1 = 0; read_en2 = 0; clr = 0;
    for (int k = 0; k < 2; k++) begin
      qbusy.push_back(1'b0);
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (mon_en) begin
      if (qbusy.size() == 0) bad("busy_queue_empty");
      else chk("busy", busy, qbusy.pop_front());

      if (qdrop.size() > 0 && qdrop[0] <= cyc) begin
        void'(qdrop.pop_front());
        chk("write_drop", write_drop, 1);
      end else begin
        chk("write_drop_idle", write_drop, 0);
      end

      if (q1.size() > 0 && q1[0].stamp <= cyc) begin
        chk("read_valid1", read_valid1, 1);
        chk("read_data1", read_data1, q1[0].data);
        last1 = q1[0].data;
        void'(q1.pop_front());
      end else if (read_valid1) begin
        bad("read_valid1_unexpected");
      end else begin
        chk("read_data1_hold", read_data1, last1);
      end

      if (q2.size() > 0 && q2[0].stamp <= cyc) begin
        chk("read_valid2", read_valid2, 1);
        chk("read_data2", read_data2, q2[0].data);
        last2 = q2[0].data;
        void'(q2.pop_front());
      end else if (read_valid2) begin
        bad("read_valid2_unexpected");
      end else begin
        chk("read_data2_hold", read_data2, last2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    write_en = 0; write_add = '0; write_data = '0;
    read_en1 = 0; read_en2 = 0; read_add1 = '0; read_add2 = '0; clr = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    #1;
    chk("init_busy", busy, 0);
    chk("init_valid1", read_valid1, 0);
    chk("init_valid2", read_valid2, 0);
    chk("init_data1", read_data1, 0);
    chk("init_data2", read_data2, 0);
    chk("init_drop", write_drop, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    mon_en = 1'b1;

    // Write then read on port 1
    step(1, 3, 8'hA5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 0, 0, 0);
    // Same-edge write and dual read of the same address
    step(1, 5, 8'h3C, 1, 5, 1, 5, 0);
    idle();

    // Randomized traffic, occasional clr
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 1), AW'($urandom), DW'($urandom),
           $urandom_range(0, 1), AW'($urandom),
           $urandom_range(0, 1), AW'($urandom),
           ($urandom_range(0, 15) == 0));
    end
    settle();

    // Fill, scrub, write and read during busy, then read everything back
    for (int i = 0; i < DEPTH; i++) step(1, AW'(i), DW'(i * 17 + 1), 0, 0, 0, 0, 0);
    step(1, 2, 8'h55, 0, 0, 0, 0, 1);
    step(1, 4, 8'h66, 1, 4, 1, 1, 1);
    for (int i = 0; i < DEPTH - 1; i++) idle();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, AW'(i), 1, AW'(DEPTH - 1 - i), 0);

    // Reset during scrub cycle 4
    for (int i = 0; i < DEPTH; i++) step(1, AW'(i), DW'(8'hC0 + i), 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) idle();
    mid_reset();
    step(1, AW'(DEPTH - 1), 8'h81, 1, AW'(DEPTH - 1), 0, 0, 0);
    step(0, 0, 0, 1, AW'(DEPTH - 1), 1, 1, 0);

    // Entry 0 behaviour (hardwired zero only with the macro)
    step(1, 0, 8'hFF, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 0);

    for (int i = 0; i < 3; i++) idle();
    #2;
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("qdrop_drained", qdrop.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
